// File: rtl/mrv32_pkg.sv
// Shared core constants and types for the mrv32 data-memory path.
package mrv32_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int MEM_BYTES       = 1024;
  localparam int DMEM_RD_LATENCY = 1;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  typedef enum logic {
    DM_IDLE,
    DM_BUSY
  } dmem_state_t;

endpackage

// File: rtl/mrv32_dmem_if.sv
// b_* data bus between the load/store unit (master) and data memory (slave).
interface mrv32_dmem_if #(
  parameter int ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH
);
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [31:0]           b_wdata;
  logic [3:0]            b_wstrb;
  logic [31:0]           b_rdata;
  logic                  b_rvalid;

  modport master (
    output b_valid, b_addr, b_wdata, b_wstrb,
    input  b_rdata, b_rvalid
  );

  modport slave (
    input  b_valid, b_addr, b_wdata, b_wstrb,
    output b_rdata, b_rvalid
  );
endinterface

// File: rtl/mrv32_dmem_array.sv
// Word-organised data RAM: per-byte synchronous write, asynchronous read.
module mrv32_dmem_array #(
  parameter int    WORDS     = 256,
  parameter int    IDX_W     = 8,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  // NOTE: storage has no reset branch; clearing a RAM array forces it into flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mrv32_dmem.sv
// Data-memory slave: byte-strobed writes, fixed-latency full-word reads, overlap detection.
module mrv32_dmem
  import mrv32_pkg::*;
#(
  parameter int ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH,
  parameter int MEM_BYTES  = mrv32_pkg::MEM_BYTES,
  parameter int RD_LATENCY = mrv32_pkg::DMEM_RD_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  mrv32_dmem_if.slave        bus,
  output logic               rd_busy,
  output logic               err_ovl
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("mrv32_dmem: RD_LATENCY must be within 1..15");
  end
  if (MEM_BYTES % 4 != 0) begin : g_bad_size
    $error("mrv32_dmem: MEM_BYTES must be a multiple of 4");
  end

  dmem_state_t      state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_oor;
  logic             rvalid_q;
  logic [31:0]      rdata_hold;

  logic             in_range;
  logic [IDX_W-1:0] addr_idx;
  logic             accept;
  logic             rd_accept;
  logic             overlap;
  logic [3:0]       we;
  logic [31:0]      arr_rdata;
  logic [31:0]      word_out;

  assign in_range  = {1'b0, bus.b_addr} < MEM_LIMIT;
  assign addr_idx  = bus.b_addr[IDX_W+1:2];
  // The response cycle frees the slot, so a new request there is accepted.
  assign accept    = bus.b_valid && (state == DM_IDLE || rvalid_q);
  assign rd_accept = accept && (bus.b_wstrb == WSTRB_NONE);
  assign overlap   = bus.b_valid && (state == DM_BUSY) && !rvalid_q;
  assign we        = (accept && in_range) ? bus.b_wstrb : 4'b0000;

  mrv32_dmem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (addr_idx),
    .wdata (bus.b_wdata),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  assign word_out     = rd_oor ? 32'h0 : arr_rdata;
  assign bus.b_rvalid = rvalid_q;
  assign bus.b_rdata  = rvalid_q ? word_out : rdata_hold;
  assign rd_busy      = (state == DM_BUSY);

  // NOTE: all state updates use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DM_IDLE;
      cnt        <= 4'd0;
      rd_idx     <= '0;
      rd_oor     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_hold <= 32'h0;
      err_ovl    <= 1'b0;
    end else begin
      if (rvalid_q) rdata_hold <= word_out;
      if (overlap)  err_ovl    <= 1'b1;
      rvalid_q <= 1'b0;
      if (rd_accept) begin
        state    <= DM_BUSY;
        cnt      <= 4'(RD_LATENCY);
        rd_idx   <= in_range ? addr_idx : '0;
        rd_oor   <= !in_range;
        rvalid_q <= (RD_LATENCY == 1);
      end else if (state == DM_BUSY) begin
        if (cnt == 4'd1) begin
          state <= DM_IDLE;
          cnt   <= 4'd0;
        end else begin
          cnt      <= cnt - 4'd1;
          rvalid_q <= (cnt == 4'd2);
        end
      end
    end
  end

endmodule

// File: tb/tb_mrv32_dmem.sv
// Directed bench for mrv32_dmem with three instances at read latencies 1, 3 and 4.
module tb_mrv32_dmem;
  import mrv32_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic busy1, busy3, busy4;
  logic err1, err3, err4;

  mrv32_dmem_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus1 ();
  mrv32_dmem_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus3 ();
  mrv32_dmem_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus4 ();

  mrv32_dmem #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .rd_busy(busy1), .err_ovl(err1));
  mrv32_dmem #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .rd_busy(busy3), .err_ovl(err3));
  mrv32_dmem #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES), .RD_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .rd_busy(busy4), .err_ovl(err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic v, input logic [ADDR_WIDTH-1:0] a,
                     input logic [31:0] wd, input logic [3:0] ws);
    case (d)
      1: begin bus1.b_valid = v; bus1.b_addr = a; bus1.b_wdata = wd; bus1.b_wstrb = ws; end
      3: begin bus3.b_valid = v; bus3.b_addr = a; bus3.b_wdata = wd; bus3.b_wstrb = ws; end
      default: begin bus4.b_valid = v; bus4.b_addr = a; bus4.b_wdata = wd; bus4.b_wstrb = ws; end
    endcase
  endtask

  task automatic wr(input int d, input logic [ADDR_WIDTH-1:0] a, input logic [31:0] wd,
                    input logic [3:0] ws);
    drv(d, 1'b1, a, wd, ws);
  endtask

  task automatic rd(input int d, input logic [ADDR_WIDTH-1:0] a);
    drv(d, 1'b1, a, 32'h0, WSTRB_NONE);
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, '0, 32'h0, 4'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle(1); idle(3); idle(4);
    tick(); tick();
    check("rst_rvalid1", 32'(bus1.b_rvalid), 32'h0);
    check("rst_rdata1",  bus1.b_rdata,       32'h0);
    check("rst_busy1",   32'(busy1),         32'h0);
    check("rst_err1",    32'(err1),          32'h0);
    rst_n = 1'b1;
    tick();

    // Full-word write then LAT=1 read, one-cycle pulse
    wr(1, 'h10, 32'hDEADBEEF, 4'b1111);
    tick();
    check("t1_wr_nobusy", 32'(busy1), 32'h0);
    rd(1, 'h10);
    tick();
    check("t1_rvalid", 32'(bus1.b_rvalid), 32'h1);
    check("t1_rdata",  bus1.b_rdata,       32'hDEADBEEF);
    check("t1_busy",   32'(busy1),         32'h1);
    idle(1);
    tick();
    check("t1_pulse_end", 32'(bus1.b_rvalid), 32'h0);
    check("t1_idle_busy", 32'(busy1),         32'h0);
    check("t1_rdata_hold", bus1.b_rdata,      32'hDEADBEEF);

    // Single-lane write merges into existing word
    wr(1, 'h10, 32'h11223344, 4'b1111);
    tick();
    wr(1, 'h13, 32'hAA000000, 4'b1000);
    tick();
    rd(1, 'h10);
    tick();
    check("t2_rvalid", 32'(bus1.b_rvalid), 32'h1);
    check("t2_rdata",  bus1.b_rdata,       32'hAA223344);
    idle(1);
    tick();

    // Back-to-back reads: second request in the response cycle
    wr(1, 'h20, 32'h20202020, 4'b1111);
    tick();
    wr(1, 'h24, 32'h24242424, 4'b1111);
    tick();
    rd(1, 'h20);
    tick();
    check("t4_rvalid_a", 32'(bus1.b_rvalid), 32'h1);
    check("t4_rdata_a",  bus1.b_rdata,       32'h20202020);
    rd(1, 'h24);
    tick();
    check("t4_rvalid_b", 32'(bus1.b_rvalid), 32'h1);
    check("t4_rdata_b",  bus1.b_rdata,       32'h24242424);
    idle(1);
    tick();
    check("t4_rvalid_end", 32'(bus1.b_rvalid), 32'h0);
    check("t4_err",        32'(err1),          32'h0);

    // Out-of-range: write dropped (no alias onto word 0), read returns zero
    wr(1, 'h0, 32'h01020304, 4'b1111);
    tick();
    wr(1, ADDR_WIDTH'(MEM_BYTES), 32'hFFFFFFFF, 4'b1111);
    tick();
    rd(1, ADDR_WIDTH'(MEM_BYTES));
    tick();
    check("oor_rvalid", 32'(bus1.b_rvalid), 32'h1);
    check("oor_rdata",  bus1.b_rdata,       32'h0);
    rd(1, 'h0);
    tick();
    check("oor_no_alias", bus1.b_rdata, 32'h01020304);
    idle(1);
    tick();

    // LAT=4 timing: request in cycle 10, response in cycle 14
    wr(4, 'h40, 32'hCAFEF00D, 4'b1111);
    tick();
    rd(4, 'h40);
    tick();
    idle(4);
    for (int c = 11; c <= 13; c++) begin
      check($sformatf("t3_busy_c%0d", c),   32'(busy4),         32'h1);
      check($sformatf("t3_rvalid_c%0d", c), 32'(bus4.b_rvalid), 32'h0);
      tick();
    end
    check("t3_rvalid_c14", 32'(bus4.b_rvalid), 32'h1);
    check("t3_busy_c14",   32'(busy4),         32'h1);
    check("t3_rdata_c14",  bus4.b_rdata,       32'hCAFEF00D);
    tick();
    check("t3_rvalid_c15", 32'(bus4.b_rvalid), 32'h0);
    check("t3_busy_c15",   32'(busy4),         32'h0);

    // LAT=3 overlap: write during BUSY ignored, err_ovl set, response on time
    wr(3, 'h20, 32'h12345678, 4'b1111);
    tick();
    wr(3, 'h30, 32'h30303030, 4'b1111);
    tick();
    rd(3, 'h30);
    tick();
    check("t5_busy",      32'(busy3), 32'h1);
    check("t5_err_clear", 32'(err3),  32'h0);
    wr(3, 'h20, 32'h00000055, 4'b0001);
    tick();
    idle(3);
    check("t5_err_set",   32'(err3),         32'h1);
    check("t5_no_early",  32'(bus3.b_rvalid), 32'h0);
    tick();
    check("t5_rvalid",    32'(bus3.b_rvalid), 32'h1);
    check("t5_rdata",     bus3.b_rdata,       32'h30303030);
    tick();
    rd(3, 'h20);
    tick();
    idle(3);
    tick();
    tick();
    check("t5_old_rvalid", 32'(bus3.b_rvalid), 32'h1);
    check("t5_old_data",   bus3.b_rdata,       32'h12345678);
    check("t5_err_sticky", 32'(err3),          32'h1);
    tick();

    // LAT=4 out-of-range read completes on time with zero data
    rd(4, ADDR_WIDTH'(MEM_BYTES));
    tick();
    idle(4);
    tick(); tick(); tick();
    check("t6_oor_rvalid", 32'(bus4.b_rvalid), 32'h1);
    check("t6_oor_rdata",  bus4.b_rdata,       32'h0);
    tick();

    // Reset mid-read cancels the response and clears err_ovl
    rd(4, 'h40);
    tick();
    idle(4);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",   32'(busy4),         32'h0);
    check("t6_rst_rvalid", 32'(bus4.b_rvalid), 32'h0);
    check("t6_rst_rdata",  bus4.b_rdata,       32'h0);
    check("t6_rst_err3",   32'(err3),          32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t6_post_rvalid_%0d", c), 32'(bus4.b_rvalid), 32'h0);
      check($sformatf("t6_post_busy_%0d", c),   32'(busy4),         32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
